// File: rtl/an_sec_decoder_seq.sv
// an_sec_decoder_seq: bit-serial single-error-correcting decoder for AN codes.
// The residue mod A is accumulated MSB-first. The matching arithmetic error
// +/-2^i is then found by stepping through 2^i mod A. Because of this, no
// residue lookup table is needed, and the block can be re-parametrised freely.
module an_sec_decoder_seq #(
  parameter int CW_W = 41,
  parameter int A    = 83,
  parameter int R_W  = 7,
  parameter int P_W  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW_W-1:0] in_cw,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW_W-1:0] out_cw,
  output logic [1:0]      out_status,
  output logic [P_W-1:0]  out_pos,
  output logic            out_sign
);

  typedef enum logic [2:0] {IDLE, REM, SEARCH, CORR, DONE} state_t;

  localparam logic [R_W:0]    A_X  = (R_W+1)'(A);
  localparam logic [R_W-1:0]  A_R  = R_W'(A);
  localparam logic [P_W-1:0]  LAST = P_W'(CW_W - 1);
  localparam logic [CW_W-1:0] ONE  = CW_W'(1);

  state_t          state;
  logic [CW_W-1:0] cw_q;
  logic [R_W-1:0]  r;
  logic [R_W-1:0]  p;
  logic [P_W-1:0]  i;
  logic [P_W-1:0]  k;
  logic [P_W-1:0]  pos_q;
  logic            sign_q;

  logic [R_W:0]    t, t_sub, p2, p2_sub;
  logic [R_W-1:0]  r_next, p_next, a_minus_p;
  logic [CW_W-1:0] cw_corr;

  // Acceptance is allowed only while idle and out of reset.
  assign in_ready = (state == IDLE) && !rst;

  // Next-step arithmetic: residue step, power-of-two step, and correction.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path; otherwise a latch is inferred.
    t         = {r, cw_q[k]};
    t_sub     = t - A_X;
    r_next    = (t >= A_X) ? t_sub[R_W-1:0] : t[R_W-1:0];
    p2        = {p, 1'b0};
    p2_sub    = p2 - A_X;
    p_next    = (p2 >= A_X) ? p2_sub[R_W-1:0] : p2[R_W-1:0];
    a_minus_p = A_R - p;
    cw_corr   = sign_q ? (cw_q + (ONE << pos_q)) : (cw_q - (ONE << pos_q));
  end

  // Control FSM and datapath registers. Outputs are loaded only when entering DONE.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (rst) begin
      state      <= IDLE;
      cw_q       <= '0;
      r          <= '0;
      p          <= '0;
      i          <= '0;
      k          <= '0;
      pos_q      <= '0;
      sign_q     <= 1'b0;
      out_valid  <= 1'b0;
      out_cw     <= '0;
      out_status <= 2'd0;
      out_pos    <= '0;
      out_sign   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cw_q  <= in_cw;
            r     <= '0;
            k     <= LAST;
            state <= REM;
          end
        end
        REM: begin
          r <= r_next;
          if (k == '0) begin
            if (r_next == '0) begin
              out_cw     <= cw_q;
              out_status <= 2'd0;
              out_pos    <= '0;
              out_sign   <= 1'b0;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              p     <= R_W'(1);
              i     <= '0;
              state <= SEARCH;
            end
          end else begin
            k <= k - 1'b1;
          end
        end
        SEARCH: begin
          if (r == p) begin
            pos_q  <= i;
            sign_q <= 1'b0;
            state  <= CORR;
          end else if (r == a_minus_p) begin
            pos_q  <= i;
            sign_q <= 1'b1;
            state  <= CORR;
          end else if (i == LAST) begin
            out_cw     <= cw_q;
            out_status <= 2'd2;
            out_pos    <= '0;
            out_sign   <= 1'b0;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            p <= p_next;
            i <= i + 1'b1;
          end
        end
        CORR: begin
          out_cw     <= cw_corr;
          out_status <= 2'd1;
          out_pos    <= pos_q;
          out_sign   <= sign_q;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
